wpa2_mem_arbiter: RTL and testbench
===================================

WPA2_MEM_ARBITER -- requirements
Module: wpa2_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word address width (4096 words).
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width = DATA_W/8.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports m0_address/m1_address  input  ADDR_W  requester word address.
REQ-006 SHALL have ports m0_read/m1_read  input  1  read request.
REQ-007 SHALL have ports m0_write/m1_write  input  1  write request.
REQ-008 SHALL have ports m0_byteenable/m1_byteenable  input  DATA_W/8  write byte lanes.
REQ-009 SHALL have ports m0_writedata/m1_writedata  input  DATA_W  write data.
REQ-010 SHALL have ports m0_waitrequest/m1_waitrequest  output  1  request not accepted this cycle.
REQ-011 SHALL have ports m0_readdata/m1_readdata  output  DATA_W  read data.
REQ-012 SHALL have ports m0_readdatavalid/m1_readdatavalid  output  1  readdata qualifier.
REQ-013 SHALL have port mem_address  output  ADDR_W  RAM address, registered.
REQ-014 SHALL have port mem_byteenable  output  DATA_W/8  RAM byte enables, registered.
REQ-015 SHALL have port mem_writedata  output  DATA_W  RAM write data, registered.
REQ-016 SHALL have ports mem_chipselect/mem_write  output  1  RAM strobes, registered.
REQ-017 SHALL have port mem_readdata  input  DATA_W  RAM q, valid one cycle after mem_* presented.

Function
REQ-018 Request of mX = mX_read | mX_write; write with read asserted together SHALL be a write only.
REQ-019 At most one request SHALL be accepted per cycle; accepted = request & ~waitrequest.
REQ-020 mX_waitrequest SHALL equal request_X & ~grant_X (combinational); idle requester sees 0.
REQ-021 Single requester SHALL be granted immediately, every cycle (back-to-back, no bubble).
REQ-022 Both requesting: grant SHALL go to the port not in last_served; last_served updates on each accept.
REQ-023 Accept at edge N SHALL register command to mem_* in cycle N+1; mem_chipselect=1, mem_write=1 for writes only.
REQ-024 Cycle with no accept SHALL drive mem_chipselect=0, mem_write=0 next cycle; address/data hold.
REQ-025 Read accepted at edge N SHALL give mX_readdatavalid=1 in cycle N+2 only, mX_readdata=mem_readdata.
REQ-026 Read tag pipeline (2 stages, valid + owner) SHALL route readdatavalid to the issuing port only; the other port's readdatavalid stays 0.
REQ-027 mX_readdata SHALL be mem_readdata for both ports; only readdatavalid is steered.
REQ-028 Up to 2 reads SHALL be in flight; throughput 1 access/cycle, no read or write dropped.
REQ-029 Access order SHALL equal accept order: a read accepted after a write to the same address returns the new data.
REQ-030 Writes SHALL produce no readdatavalid.
REQ-031 Request deasserted while waitrequest=1 SHALL be legal and cancel nothing internally.

Reset
REQ-032 reset SHALL asynchronously clear: last_served=1 (m0 wins first tie), read tag pipeline, mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata to 0.
REQ-033 During reset both readdatavalid SHALL be 0; waitrequest SHALL be 1 for any requester.
REQ-034 Reads in flight at reset assertion SHALL be discarded; no readdatavalid after reset release.
REQ-035 First accept SHALL be possible on the first clk edge after reset deasserts.

Verification
REQ-036 m0 write addr 0x010 data 0xDEADBEEF be 0xF, then m1 read 0x010 -> m1_readdatavalid 2 cycles after accept, m1_readdata 0xDEADBEEF, m0_readdatavalid stays 0.
REQ-037 Both read continuously addrs 0x000..0x007 -> accepts alternate m0,m1,m0,...; each port gets 8 valids, correct data, none swapped.
REQ-038 m0 write be 0x3 data 0x11112222 over 0xAAAAAAAA at 0x100, read back -> 0xAAAA2222.
REQ-039 m1 read accepted, reset asserted next cycle for 1 cycle -> no readdatavalid on either port; outputs at REQ-032 values.
REQ-040 m0 read+write same cycle addr 0x020 data 0x5 -> one write, no readdatavalid; later read 0x020 returns 0x5.
REQ-041 Single requester m0 issues 16 back-to-back reads -> m0_waitrequest never 1, 16 consecutive valid cycles.

Source files
------------

// File: rtl/wpa2_mem_arbiter.sv
// wpa2_mem_arbiter
// Two-requester arbiter in front of a single-port synchronous RAM with a
// one-cycle read latency. One access is accepted per cycle; ties alternate
// between the requesters, and m0 wins the first tie after reset.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   mX_address/read/write      requester X command (write wins over read)
//   mX_byteenable/writedata    requester X write lanes and data
//   mX_waitrequest             requester X command not accepted this cycle
//   mX_readdata/readdatavalid  read return; data is shared, valid is steered
//   mem_*                      registered RAM command; mem_readdata is RAM q
module wpa2_mem_arbiter #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   input  logic [DATA_W-1:0]     mem_readdata
);

   localparam int unsigned BE_W = DATA_W / 8;

   typedef enum logic {
      SRV_M0 = 1'b0,
      SRV_M1 = 1'b1
   } served_e;

   served_e             last_served_q, last_served_d;
   logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
   logic [BE_W-1:0]     mem_byteenable_q, mem_byteenable_d;
   logic [DATA_W-1:0]   mem_writedata_q, mem_writedata_d;
   logic                mem_chipselect_q, mem_chipselect_d;
   logic                mem_write_q, mem_write_d;
   // Read tag pipeline: stage 1 lines up with the RAM command, stage 2
   // with the RAM q one cycle later.
   logic                rd1_vld_q, rd1_vld_d, rd1_own_q, rd1_own_d;
   logic                rd2_vld_q, rd2_own_q;

   logic                req0, req1, grant0, grant1, acc_any, sel_write;

   always_comb begin
      req0 = m0_read | m0_write;
      req1 = m1_read | m1_write;
      // Nothing is accepted while reset is held, so any requester stalls.
      grant0 = req0 & ~reset & (~req1 | (last_served_q == SRV_M1));
      grant1 = req1 & ~reset & (~req0 | (last_served_q == SRV_M0));
      acc_any = grant0 | grant1;
      sel_write = grant1 ? m1_write : m0_write;

      last_served_d    = last_served_q;
      mem_address_d    = mem_address_q;
      mem_byteenable_d = mem_byteenable_q;
      mem_writedata_d  = mem_writedata_q;
      mem_chipselect_d = acc_any;
      mem_write_d      = acc_any & sel_write;
      rd1_vld_d        = acc_any & ~sel_write;
      rd1_own_d        = grant1;

      if (acc_any) begin
         last_served_d = grant1 ? SRV_M1 : SRV_M0;
         if (grant1) begin
            mem_address_d    = m1_address;
            mem_byteenable_d = m1_byteenable;
            mem_writedata_d  = m1_writedata;
         end else begin
            mem_address_d    = m0_address;
            mem_byteenable_d = m0_byteenable;
            mem_writedata_d  = m0_writedata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_served_q    <= SRV_M1;
         mem_address_q    <= '0;
         mem_byteenable_q <= '0;
         mem_writedata_q  <= '0;
         mem_chipselect_q <= 1'b0;
         mem_write_q      <= 1'b0;
         rd1_vld_q        <= 1'b0;
         rd1_own_q        <= 1'b0;
         rd2_vld_q        <= 1'b0;
         rd2_own_q        <= 1'b0;
      end else begin
         last_served_q    <= last_served_d;
         mem_address_q    <= mem_address_d;
         mem_byteenable_q <= mem_byteenable_d;
         mem_writedata_q  <= mem_writedata_d;
         mem_chipselect_q <= mem_chipselect_d;
         mem_write_q      <= mem_write_d;
         rd1_vld_q        <= rd1_vld_d;
         rd1_own_q        <= rd1_own_d;
         rd2_vld_q        <= rd1_vld_q;
         rd2_own_q        <= rd1_own_q;
      end
   end

   assign m0_waitrequest   = req0 & ~grant0;
   assign m1_waitrequest   = req1 & ~grant1;
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = rd2_vld_q & ~rd2_own_q;
   assign m1_readdatavalid = rd2_vld_q &  rd2_own_q;
   assign mem_address      = mem_address_q;
   assign mem_byteenable   = mem_byteenable_q;
   assign mem_writedata    = mem_writedata_q;
   assign mem_chipselect   = mem_chipselect_q;
   assign mem_write        = mem_write_q;

endmodule

// File: tb/tb_wpa2_mem_arbiter.sv
// Bench for wpa2_mem_arbiter: a one-cycle-latency RAM behind the DUT, and a
// transaction-level reference (arbitration rule, word memory, queue of
// expected read returns) checked every cycle.
module tb_wpa2_mem_arbiter;

   localparam int AW = 12;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] m0_address, m1_address;
   logic          m0_read, m0_write, m1_read, m1_write;
   logic [3:0]    m0_byteenable, m1_byteenable;
   logic [DW-1:0] m0_writedata, m1_writedata;
   logic          m0_waitrequest, m1_waitrequest;
   logic [DW-1:0] m0_readdata, m1_readdata;
   logic          m0_readdatavalid, m1_readdatavalid;
   logic [AW-1:0] mem_address;
   logic [3:0]    mem_byteenable;
   logic [DW-1:0] mem_writedata;
   logic          mem_chipselect, mem_write;
   logic [DW-1:0] mem_readdata = '0;

   always #5 clk = ~clk;

   wpa2_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_readdata(mem_readdata)
   );

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old_w & ~m) | (new_w & m);
   endfunction

   // RAM attached to the DUT
   logic [31:0] ram [0:4095];
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
         else           mem_readdata <= ram[mem_address];
      end
   end

   // Reference state
   typedef struct { int due; int owner; logic [31:0] data; } rd_t;
   logic [31:0] mdl [0:4095];
   rd_t         pend[$];
   int          ls;
   logic        exp_cs, exp_we;
   logic [11:0] exp_addr;
   logic [3:0]  exp_be;
   logic [31:0] exp_wd;
   int          cyc;
   int          n_tests = 0, n_fail = 0;
   bit          acc0_last, acc1_last;
   int          dv0, dv1, run0, max_run0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic idle();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
   endtask

   task automatic model_reset();
      pend.delete();
      ls = 1;
      exp_cs = 0; exp_we = 0; exp_addr = '0; exp_be = '0; exp_wd = '0;
   endtask

   // One clock: check DUT against the reference at the negedge, then apply
   // this cycle's accept (if any) to the reference.
   task automatic step();
      bit r0, r1, wr;
      int g;
      logic [11:0] a;
      rd_t e;
      @(negedge clk);
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      if (r0 && r1) g = (ls == 0) ? 1 : 0;
      else if (r0)  g = 0;
      else if (r1)  g = 1;
      else          g = -1;
      check("m0_waitrequest", m0_waitrequest, r0 && g != 0);
      check("m1_waitrequest", m1_waitrequest, r1 && g != 1);
      if (pend.size() > 0 && pend[0].due == cyc) begin
         e = pend.pop_front();
         check("m0_readdatavalid", m0_readdatavalid, e.owner == 0);
         check("m1_readdatavalid", m1_readdatavalid, e.owner == 1);
         check(e.owner == 1 ? "m1_readdata" : "m0_readdata",
               e.owner == 1 ? m1_readdata : m0_readdata, e.data);
      end else begin
         check("m0_readdatavalid", m0_readdatavalid, 0);
         check("m1_readdatavalid", m1_readdatavalid, 0);
      end
      dv0 += m0_readdatavalid;
      dv1 += m1_readdatavalid;
      run0 = m0_readdatavalid ? run0 + 1 : 0;
      if (run0 > max_run0) max_run0 = run0;
      check("mem_chipselect", mem_chipselect, exp_cs);
      check("mem_write", mem_write, exp_we);
      check("mem_address", mem_address, exp_addr);
      if (exp_we) begin
         check("mem_byteenable", mem_byteenable, exp_be);
         check("mem_writedata", mem_writedata, exp_wd);
      end
      acc0_last = (g == 0);
      acc1_last = (g == 1);
      exp_cs = (g >= 0);
      exp_we = 0;
      if (g >= 0) begin
         wr = (g == 1) ? m1_write : m0_write;
         a  = (g == 1) ? m1_address : m0_address;
         exp_we = wr;
         exp_addr = a;
         if (wr) begin
            exp_be = (g == 1) ? m1_byteenable : m0_byteenable;
            exp_wd = (g == 1) ? m1_writedata : m0_writedata;
            mdl[a] = merge(mdl[a], exp_wd, exp_be);
         end else begin
            pend.push_back('{due: cyc + 2, owner: g, data: mdl[a]});
         end
         ls = g;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_m0_rdv"}, m0_readdatavalid, 0);
      check({tag, "_m1_rdv"}, m1_readdatavalid, 0);
      check({tag, "_cs"}, mem_chipselect, 0);
      check({tag, "_we"}, mem_write, 0);
      check({tag, "_addr"}, mem_address, 0);
      check({tag, "_be"}, mem_byteenable, 0);
      check({tag, "_wd"}, mem_writedata, 0);
      check({tag, "_m0_wait"}, m0_waitrequest, m0_read | m0_write);
      check({tag, "_m1_wait"}, m1_waitrequest, m1_read | m1_write);
   endtask

   initial begin
      int a0, a1, guard;
      for (int i = 0; i < 4096; i++) begin
         ram[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
         mdl[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
      end
      cyc = 0; dv0 = 0; dv1 = 0; run0 = 0; max_run0 = 0;
      m0_address = '0; m1_address = '0; m0_byteenable = '0; m1_byteenable = '0;
      m0_writedata = '0; m1_writedata = '0;
      idle();
      reset = 1;
      #2;
      m0_read = 1; m1_write = 1;
      #1;
      check_reset_outputs("rst0");
      @(posedge clk); cyc++; #1;
      reset = 0;
      idle();
      model_reset();

      // m0 write then m1 read of the same word
      m0_write = 1; m0_address = 12'h010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
      step();
      idle();
      m1_read = 1; m1_address = 12'h010;
      step();
      idle();
      repeat (3) step();

      // Both reading 0..7 continuously: accepts alternate
      a0 = 0; a1 = 0; guard = 0; dv0 = 0; dv1 = 0;
      while ((a0 < 8 || a1 < 8) && guard < 64) begin
         m0_read = (a0 < 8); m0_address = 12'(a0);
         m1_read = (a1 < 8); m1_address = 12'(a1);
         step();
         if (acc0_last) a0++;
         if (acc1_last) a1++;
         guard++;
      end
      idle();
      repeat (3) step();
      check("alt_m0_valids", dv0, 8);
      check("alt_m1_valids", dv1, 8);

      // Partial byte write
      m0_write = 1; m0_address = 12'h100; m0_writedata = 32'hAAAAAAAA; m0_byteenable = 4'hF;
      step();
      m0_writedata = 32'h11112222; m0_byteenable = 4'h3;
      step();
      m0_write = 0; m0_read = 1;
      step();
      idle();
      repeat (3) step();

      // Read and write asserted together is a write only
      m0_read = 1; m0_write = 1; m0_address = 12'h020; m0_writedata = 32'h5; m0_byteenable = 4'hF;
      step();
      idle();
      repeat (3) step();
      m0_read = 1;
      step();
      idle();
      repeat (3) step();

      // 16 back-to-back reads from m0 alone
      dv0 = 0; run0 = 0; max_run0 = 0;
      for (int i = 0; i < 16; i++) begin
         m0_read = 1; m0_address = 12'(12'h040 + i);
         step();
      end
      idle();
      repeat (3) step();
      check("b2b_m0_valids", dv0, 16);
      check("b2b_m0_run", max_run0, 16);

      // Randomized traffic over a small address window
      for (int i = 0; i < 400; i++) begin
         int op0, op1;
         op0 = $urandom_range(0, 3);
         op1 = $urandom_range(0, 3);
         m0_read = op0[0]; m0_write = op0[1];
         m1_read = op1[0]; m1_write = op1[1];
         m0_address = 12'($urandom_range(0, 15));
         m1_address = 12'($urandom_range(0, 15));
         m0_writedata = $urandom; m1_writedata = $urandom;
         m0_byteenable = 4'($urandom_range(0, 15));
         m1_byteenable = 4'($urandom_range(0, 15));
         step();
      end
      idle();
      repeat (3) step();

      // Reset while an m1 read is in flight
      m1_read = 1; m1_address = 12'h123;
      step();
      reset = 1;
      #1;
      check_reset_outputs("rst1");
      @(posedge clk); cyc++; #1;
      reset = 0;
      idle();
      model_reset();
      dv0 = 0; dv1 = 0;
      repeat (4) step();
      check("rst1_no_m0_valid", dv0, 0);
      check("rst1_no_m1_valid", dv1, 0);

      // Tie right after reset goes to m0
      m0_read = 1; m0_address = 12'h005; m1_read = 1; m1_address = 12'h006;
      step();
      step();
      idle();
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
